// File: rtl/ni_local_tx.sv
`default_nettype none
// ==========================================================================
// ni_local_tx : PE-side NI transmitter, header + PKT_LEN-1 body flits under
// credit flow control. Rev 1.0 | optional stats: NI_LOCAL_TX_STATS_EN
// ==========================================================================
module ni_local_tx #(
    parameter int BUF_DEPTH = 8,
    parameter int CRED_W    = 4,
    parameter int PKT_LEN   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    input  logic [15:0]       cmd_dest_i,
    output logic              cmd_ready_o,
    input  logic              pl_valid_i,
    input  logic [15:0]       pl_data_i,
    output logic              pl_ready_o,
    output logic [15:0]       l_data_o,
    output logic              l_valid_o,
    input  logic              l_credit_i,
    output logic [CRED_W-1:0] credit_o,
    output logic              busy_o,
    output logic              pkt_sent_o,
    output logic              cred_err_o
`ifdef NI_LOCAL_TX_STATS_EN
    ,
    output logic [15:0]       pkt_count_o,
    output logic [15:0]       stall_cycles_o
`endif
);

    localparam logic [1:0]        c_S_IDLE   = 2'd0;
    localparam logic [1:0]        c_S_HEAD   = 2'd1;
    localparam logic [1:0]        c_S_BODY   = 2'd2;
    localparam logic [CRED_W-1:0] c_CRED_MAX = CRED_W'(BUF_DEPTH);
    localparam logic [3:0]        c_LAST_CNT = 4'(PKT_LEN - 2);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [15:0]       r_dest;
    logic [3:0]        r_cnt;
    logic [CRED_W-1:0] r_credit;
    logic              r_cred_err;
    logic [15:0]       r_l_data;
    logic              r_l_valid;
    logic              r_pkt_sent;

    logic              w_can_send;
    logic              w_cmd_ready;
    logic              w_pl_ready;
    logic              w_launch;
    logic              w_last;
    logic [15:0]       w_launch_data;

    // A credit returned this cycle only becomes usable next cycle.
    assign w_can_send = (r_credit != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (cmd_valid_i) w_state_nxt = c_S_HEAD;
            c_S_HEAD: if (w_can_send)  w_state_nxt = c_S_BODY;
            c_S_BODY: if (w_last)      w_state_nxt = c_S_IDLE;
            default:                   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready   = 1'b0;
        w_pl_ready    = 1'b0;
        w_launch      = 1'b0;
        w_last        = 1'b0;
        w_launch_data = r_dest;
        case (r_state)
            c_S_IDLE: w_cmd_ready = reset;
            c_S_HEAD: w_launch    = w_can_send;
            c_S_BODY: begin
                w_pl_ready    = reset & w_can_send;
                w_launch      = pl_valid_i & w_pl_ready;
                w_launch_data = pl_data_i;
                w_last        = w_launch && (r_cnt == c_LAST_CNT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dest     <= '0;
            r_cnt      <= '0;
            r_l_data   <= '0;
            r_l_valid  <= 1'b0;
            r_pkt_sent <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE && cmd_valid_i) begin
                r_dest <= cmd_dest_i;
            end
            if (w_launch) begin
                r_l_data <= w_launch_data;
                r_cnt    <= (r_state == c_S_HEAD) ? 4'd0 : r_cnt + 4'd1;
            end
            r_l_valid  <= w_launch;
            r_pkt_sent <= w_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_credit   <= c_CRED_MAX;
            r_cred_err <= 1'b0;
        end else begin
            case ({w_launch, l_credit_i})
                2'b10: r_credit <= r_credit - 1'b1;
                2'b01: begin
                    if (r_credit == c_CRED_MAX) begin
                        r_cred_err <= 1'b1;
                    end else begin
                        r_credit <= r_credit + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NI_LOCAL_TX_STATS_EN
    logic [15:0] r_pkt_count;
    logic [15:0] r_stall_cycles;
    logic        w_stall;

    assign w_stall = ((r_state == c_S_HEAD) || (r_state == c_S_BODY && pl_valid_i))
                     && !w_can_send;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pkt_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_pkt_sent && r_pkt_count != 16'hFFFF) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_stall && r_stall_cycles != 16'hFFFF) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign pkt_count_o    = r_pkt_count;
    assign stall_cycles_o = r_stall_cycles;
`endif

    assign cmd_ready_o = w_cmd_ready;
    assign pl_ready_o  = w_pl_ready;
    assign l_data_o    = r_l_data;
    assign l_valid_o   = r_l_valid;
    assign credit_o    = r_credit;
    assign busy_o      = (r_state != c_S_IDLE);
    assign pkt_sent_o  = r_pkt_sent;
    assign cred_err_o  = r_cred_err;

endmodule
`default_nettype wire

// File: tb/tb_ni_local_tx.sv
`default_nettype none
// ==========================================================================
// tb_ni_local_tx : directed + randomized bench with a packet-level model.
// Rev 1.0
// ==========================================================================
module tb_ni_local_tx;

    localparam int BUF_DEPTH = 8;
    localparam int CRED_W    = 4;
    localparam int PKT_LEN   = 4;
    localparam int BUDGET    = 300;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic [15:0]       cmd_dest_i = '0;
    logic              cmd_ready_o;
    logic              pl_valid_i = 1'b0;
    logic [15:0]       pl_data_i = '0;
    logic              pl_ready_o;
    logic [15:0]       l_data_o;
    logic              l_valid_o;
    logic              l_credit_i = 1'b0;
    logic [CRED_W-1:0] credit_o;
    logic              busy_o;
    logic              pkt_sent_o;
    logic              cred_err_o;
`ifdef NI_LOCAL_TX_STATS_EN
    logic [15:0]       pkt_count_o;
    logic [15:0]       stall_cycles_o;
`endif

    always #5 clk = ~clk;

    ni_local_tx #(.BUF_DEPTH(BUF_DEPTH), .CRED_W(CRED_W), .PKT_LEN(PKT_LEN)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_dest_i     (cmd_dest_i),
        .cmd_ready_o    (cmd_ready_o),
        .pl_valid_i     (pl_valid_i),
        .pl_data_i      (pl_data_i),
        .pl_ready_o     (pl_ready_o),
        .l_data_o       (l_data_o),
        .l_valid_o      (l_valid_o),
        .l_credit_i     (l_credit_i),
        .credit_o       (credit_o),
        .busy_o         (busy_o),
        .pkt_sent_o     (pkt_sent_o),
        .cred_err_o     (cred_err_o)
`ifdef NI_LOCAL_TX_STATS_EN
        ,
        .pkt_count_o    (pkt_count_o),
        .stall_cycles_o (stall_cycles_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out after %0d cycles (t=%0t)", name, BUDGET, $time);
    endtask

    // Packet-level model: position within the packet (0 = header pending)
    bit          m_active = 0;
    int          m_idx    = 0;
    logic [15:0] m_dest   = '0;
    int          m_credit = BUF_DEPTH;
    bit          m_err    = 0;
    bit          m_lv     = 0;
    logic [15:0] m_ld     = '0;
    bit          m_sent   = 0;
    int          m_pkt    = 0;
    int          m_stall  = 0;
    bit          ck_en    = 0;

    task automatic model_step();
        bit          launch;
        bit          last;
        bit          act;
        int          idx;
        int          cred;
        logic [15:0] d;
        if (!reset) begin
            m_active <= 0; m_idx <= 0; m_credit <= BUF_DEPTH; m_err <= 0;
            m_lv <= 0; m_ld <= '0; m_sent <= 0; m_pkt <= 0; m_stall <= 0;
            ck_en <= 1;
        end else begin
            launch = 0; last = 0; act = m_active; idx = m_idx; d = m_ld; cred = m_credit;
            if (!m_active) begin
                if (cmd_valid_i) begin
                    act = 1; idx = 0; m_dest <= cmd_dest_i;
                end
            end else if (m_idx == 0) begin
                if (m_credit != 0) begin
                    launch = 1; d = m_dest; idx = 1;
                end
            end else if (m_credit != 0 && pl_valid_i) begin
                launch = 1; d = pl_data_i; idx = m_idx + 1;
                if (m_idx == PKT_LEN - 1) begin
                    last = 1; act = 0;
                end
            end
            if (m_active && (m_idx == 0 || pl_valid_i) && m_credit == 0 && m_stall < 65535)
                m_stall <= m_stall + 1;
            if (m_sent && m_pkt < 65535)
                m_pkt <= m_pkt + 1;
            if (launch && !l_credit_i) begin
                cred = m_credit - 1;
            end else if (!launch && l_credit_i) begin
                if (m_credit == BUF_DEPTH) m_err <= 1;
                else cred = m_credit + 1;
            end
            m_active <= act; m_idx <= idx; m_credit <= cred;
            m_lv <= launch; m_ld <= d; m_sent <= last;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (ck_en) begin
            check("l_valid",   32'(l_valid_o),   32'(m_lv));
            check("l_data",    32'(l_data_o),    32'(m_ld));
            check("pkt_sent",  32'(pkt_sent_o),  32'(m_sent));
            check("credit",    32'(credit_o),    32'(m_credit));
            check("cred_err",  32'(cred_err_o),  32'(m_err));
            check("busy",      32'(busy_o),      32'(m_active));
            check("cmd_ready", 32'(cmd_ready_o), 32'(reset && !m_active));
            check("pl_ready",  32'(pl_ready_o),  32'(reset && m_active && m_idx != 0 && m_credit != 0));
`ifdef NI_LOCAL_TX_STATS_EN
            check("pkt_count",    32'(pkt_count_o),    32'(m_pkt));
            check("stall_cycles", 32'(stall_cycles_o), 32'(m_stall));
`endif
        end
    end

    // Flit capture and credit-flatness tracking for the directed tests
    logic [15:0] cap_q[$];
    int          cap_cyc[$];
    bit          cap_sent[$];
    int          cyc = 0;
    bit          trk = 0;
    int          cr_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (l_valid_o) begin
            cap_q.push_back(l_data_o);
            cap_cyc.push_back(cyc);
            cap_sent.push_back(pkt_sent_o);
        end
        if (trk && int'(credit_o) != BUF_DEPTH) cr_bad++;
    end

    // Credit return: 0 none, 1 every cycle, 2 random while not full, 3 while busy
    int cred_mode = 0;
    always @(posedge clk) begin
        #2;
        case (cred_mode)
            0: l_credit_i = 1'b0;
            1: l_credit_i = 1'b1;
            2: l_credit_i = (int'(credit_o) < BUF_DEPTH) && ($urandom_range(99) < 40);
            3: l_credit_i = busy_o;
            default: l_credit_i = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        cmd_valid_i = 1'b0;
        pl_valid_i = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    task automatic send_cmd(input logic [15:0] dest);
        bit done;
        done = 0;
        cmd_valid_i = 1'b1;
        cmd_dest_i  = dest;
        for (int k = 0; k < BUDGET && !done; k++) begin
            @(negedge clk);
            done = cmd_ready_o;
            tick();
        end
        cmd_valid_i = 1'b0;
        cmd_dest_i  = 16'($urandom);
        if (!done) fail_timeout("cmd_handshake");
    endtask

    task automatic send_flit(input logic [15:0] data, input int bubble_pct);
        bit done;
        done = 0;
        for (int k = 0; k < BUDGET && !done; k++) begin
            pl_valid_i = ($urandom_range(99) >= bubble_pct);
            pl_data_i  = pl_valid_i ? data : 16'($urandom);
            @(negedge clk);
            done = pl_valid_i && pl_ready_o;
            tick();
        end
        pl_valid_i = 1'b0;
        if (!done) fail_timeout("flit_handshake");
    endtask

    task automatic send_pkt(input logic [15:0] dest, input logic [15:0] base, input int bubble_pct);
        send_cmd(dest);
        for (int f = 1; f < PKT_LEN; f++) send_flit(base + 16'(f), bubble_pct);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        do_reset(3);
        check("rst_credit",   32'(credit_o),   32'd8);
        check("rst_l_valid",  32'(l_valid_o),  32'd0);
        check("rst_busy",     32'(busy_o),     32'd0);
        check("rst_cred_err", 32'(cred_err_o), 32'd0);

        // Single packet, no backpressure
        cred_mode = 0;
        cap_q.delete(); cap_cyc.delete(); cap_sent.delete();
        send_pkt(16'h0102, 16'h00A0, 0);
        tick(); tick();
        check("t1_nflits", 32'(cap_q.size()), 32'd4);
        if (cap_q.size() == 4) begin
            check("t1_hdr",    32'(cap_q[0]), 32'h0102);
            check("t1_a1",     32'(cap_q[1]), 32'h00A1);
            check("t1_a2",     32'(cap_q[2]), 32'h00A2);
            check("t1_a3",     32'(cap_q[3]), 32'h00A3);
            check("t1_span",   32'(cap_cyc[3] - cap_cyc[0]), 32'd3);
            check("t1_sent",   32'(cap_sent[3]), 32'd1);
            check("t1_nosent", 32'(cap_sent[2]), 32'd0);
        end
        check("t1_credit", 32'(credit_o), 32'd4);

        // Credit exhaustion, starvation stats and overflow
        do_reset(2);
        send_pkt(16'h0201, 16'h00B0, 0);
        send_pkt(16'h0202, 16'h00C0, 0);
        send_cmd(16'h0C03);
        repeat (4) tick();
        check("t2_credit0", 32'(credit_o),  32'd0);
        check("t2_stallv",  32'(l_valid_o), 32'd0);
        check("t2_busy",    32'(busy_o),    32'd1);
        cred_mode = 1;
        tick();
        check("t2_cred_vis", 32'(credit_o),  32'd1);
        check("t2_notyet",   32'(l_valid_o), 32'd0);
        tick();
        check("t2_hdr_v",    32'(l_valid_o), 32'd1);
        check("t2_hdr_d",    32'(l_data_o),  32'h0C03);
        for (int f = 1; f < PKT_LEN; f++) send_flit(16'h00D0 + 16'(f), 0);
        repeat (14) tick();
`ifdef NI_LOCAL_TX_STATS_EN
        check("st_pkt_count", 32'(pkt_count_o),    32'd3);
        check("st_stall",     32'(stall_cycles_o), 32'd5);
`endif
        check("ovf_credit", 32'(credit_o),   32'd8);
        check("ovf_err",    32'(cred_err_o), 32'd1);
        cred_mode = 0;
        repeat (5) tick();
        check("ovf_sticky", 32'(cred_err_o), 32'd1);
        do_reset(1);
        check("ovf_clr",    32'(cred_err_o), 32'd0);

        // Simultaneous increment and decrement
        cred_mode = 3;
        cr_bad = 0;
        trk = 1;
        send_pkt(16'h0305, 16'h00E0, 0);
        tick(); tick();
        trk = 0;
        cred_mode = 0;
        check("t3_flat",   32'(cr_bad),     32'd0);
        check("t3_noerr",  32'(cred_err_o), 32'd0);

        // PE bubble, then reset mid-packet
        do_reset(1);
        cap_q.delete(); cap_cyc.delete(); cap_sent.delete();
        send_cmd(16'h0406);
        repeat (4) tick();
        send_flit(16'h00F1, 0);
        send_flit(16'h00F2, 0);
        reset = 1'b0;
        tick();
        check("t4_rst_v",    32'(l_valid_o), 32'd0);
        check("t4_rst_cred", 32'(credit_o),  32'd8);
        check("t4_rst_busy", 32'(busy_o),    32'd0);
        reset = 1'b1;
        pl_valid_i = 1'b1;
        repeat (6) tick();
        pl_valid_i = 1'b0;
        check("t4_nflits", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3)
            check("t4_bubble", 32'(cap_cyc[1] - cap_cyc[0]), 32'd4);

        // Randomized traffic with occasional abandoned packets
        do_reset(1);
        cred_mode = 2;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(7) == 0) begin
                int nb;
                nb = $urandom_range(PKT_LEN - 2);
                send_cmd(16'($urandom));
                for (int f = 0; f < nb; f++) send_flit(16'($urandom), 30);
                do_reset(1 + $urandom_range(2));
            end else begin
                send_pkt(16'($urandom), 16'($urandom), $urandom_range(50));
            end
            repeat ($urandom_range(3)) tick();
        end
        cred_mode = 0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
